// File: rtl/divider_pkg.sv
// Shared ALU definitions for the sequential divider: FSM encodings,
// default operand width and iteration-counter sizing.
package divider_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int ALU_WIDTH = 16;

   // Counter must hold N-1; never let it collapse to zero bits.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit,
// trial-subtract the divisor and keep or restore the partial remainder.
module div_step #(
   parameter int N = 16
) (
   input  logic [N-1:0] rem_in,
   input  logic         msb,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] rem_out,
   output logic         q_bit
);

   logic [N:0]   shifted;
   logic [N-1:0] diff;

   // When the subtraction succeeds the true difference is below the
   // divisor, so an N-bit modular subtract is exact.
   always_comb begin
      shifted = {rem_in, msb};
      q_bit   = (shifted >= {1'b0, divisor});
      diff    = shifted[N-1:0] - divisor;
      rem_out = q_bit ? diff : shifted[N-1:0];
   end

endmodule

// File: rtl/divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock,
// registered results with a single-cycle finish strobe.
module divider
   import divider_pkg::*;
#(
   parameter int N = ALU_WIDTH
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         finish,
   output logic         busy,
   output logic         div_by_zero
);

   localparam int CW = cnt_width(N);

   state_t        state;
   state_t        state_nxt;
   logic [N-1:0]  dvd;
   logic [N-1:0]  dvs;
   logic [N-1:0]  prem;
   logic [N-1:0]  prem_nxt;
   logic          q_bit;
   logic [CW-1:0] cnt;

   div_step #(.N(N)) u_step (
      .rem_in  (prem),
      .msb     (dvd[N-1]),
      .divisor (dvs),
      .rem_out (prem_nxt),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = (b == '0) ? DONE : CALC;
         CALC: if (cnt == '0) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      finish = (state == DONE);
      busy   = (state != IDLE);
   end

   // Dividend register doubles as the quotient shift register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dvd         <= '0;
         dvs         <= '0;
         prem        <= '0;
         cnt         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  dvd  <= a;
                  dvs  <= b;
                  prem <= '0;
                  cnt  <= CW'(N - 1);
                  if (b == '0) begin
                     quotient    <= '1;
                     remainder   <= a;
                     div_by_zero <= 1'b1;
                  end
               end
            end
            CALC: begin
               dvd  <= {dvd[N-2:0], q_bit};
               prem <= prem_nxt;
               cnt  <= cnt - CW'(1);
               if (cnt == '0) begin
                  quotient    <= {dvd[N-2:0], q_bit};
                  remainder   <= prem_nxt;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
